// File: rtl/lpc_synth_filter.sv
// All-pole LPC synthesis filter 1/A(z): y[n] = sat(round(e[n] - sum a[k]*y[n-k])).
// Latency: sample accepted at cycle t gives y_valid at t+ORDER+2; one sample per ORDER+3 cycles.
// Backpressure: e_ready only in S_IDLE (no skid buffer); y_data held in S_OUT until y_ready.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   coef_wr_en/addr/data                coefficient write port, a[k] for k in 1..ORDER
//   hist_clr                            zero the output history (idle only)
//   e_valid/e_ready/e_data              excitation input handshake
//   y_valid/y_ready/y_data              synthesized output handshake
//   busy                                high while a sample is in flight
module lpc_synth_filter #(
    parameter int ORDER     = 10,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 12,
    parameter int ACC_W     = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     coef_wr_en,
    input  logic [3:0]               coef_wr_addr,
    input  logic signed [COEF_W-1:0] coef_wr_data,
    input  logic                     hist_clr,
    input  logic                     e_valid,
    output logic                     e_ready,
    input  logic signed [DATA_W-1:0] e_data,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic signed [DATA_W-1:0] y_data,
    output logic                     busy
);

    localparam int KW = $clog2(ORDER + 1);
    localparam int PW = COEF_W + DATA_W;

    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) <<< (COEF_FRAC - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = -ACC_W'(2 ** (DATA_W - 1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_ROUND,
        S_OUT
    } state_t;

    state_t                    state_q, state_d;
    logic signed [COEF_W-1:0]  coef_q [1:ORDER];
    logic signed [COEF_W-1:0]  coef_d [1:ORDER];
    logic signed [DATA_W-1:0]  hist_q [1:ORDER];
    logic signed [DATA_W-1:0]  hist_d [1:ORDER];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [KW-1:0]             k_q, k_d;
    logic signed [DATA_W-1:0]  y_q, y_d;

    // Shared multiplier operands, selected by the tap counter.
    logic signed [COEF_W-1:0]  mul_coef;
    logic signed [DATA_W-1:0]  mul_hist;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   rnd;
    logic signed [ACC_W-1:0]   shr;
    logic signed [DATA_W-1:0]  y_sat;

    always_comb begin
        mul_coef = '0;
        mul_hist = '0;
        for (int i = 1; i <= ORDER; i++) begin
            if (k_q == KW'(i)) begin
                mul_coef = coef_q[i];
                mul_hist = hist_q[i];
            end
        end
    end

    // Full-precision product; sign extension happens in the casts.
    assign prod = PW'(mul_coef) * PW'(mul_hist);

    // Round half up, then arithmetic shift back to sample scale.
    assign rnd = acc_q + HALF;
    assign shr = rnd >>> COEF_FRAC;

    always_comb begin
        if (shr > Y_MAX) begin
            y_sat = Y_MAX[DATA_W-1:0];
        end else if (shr < Y_MIN) begin
            y_sat = Y_MIN[DATA_W-1:0];
        end else begin
            y_sat = shr[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        coef_d  = coef_q;
        hist_d  = hist_q;
        acc_d   = acc_q;
        k_d     = k_q;
        y_d     = y_q;

        unique case (state_q)
            S_IDLE: begin
                // Write and clear land in the registers before the first MAC cycle
                // reads them, so a sample accepted this same cycle sees both.
                if (coef_wr_en) begin
                    for (int i = 1; i <= ORDER; i++) begin
                        if (coef_wr_addr == 4'(i)) begin
                            coef_d[i] = coef_wr_data;
                        end
                    end
                end
                if (hist_clr) begin
                    for (int i = 1; i <= ORDER; i++) begin
                        hist_d[i] = '0;
                    end
                end
                if (e_valid) begin
                    acc_d   = ACC_W'(e_data) <<< COEF_FRAC;
                    k_d     = KW'(1);
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q - ACC_W'(prod);
                k_d   = k_q + KW'(1);
                if (k_q == KW'(ORDER)) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                y_d       = y_sat;
                hist_d[1] = y_sat;
                for (int i = 2; i <= ORDER; i++) begin
                    hist_d[i] = hist_q[i-1];
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                if (y_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            k_q     <= '0;
            y_q     <= '0;
            for (int i = 1; i <= ORDER; i++) begin
                coef_q[i] <= '0;
                hist_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            y_q     <= y_d;
            for (int i = 1; i <= ORDER; i++) begin
                coef_q[i] <= coef_d[i];
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign e_ready = (state_q == S_IDLE);
    assign y_valid = (state_q == S_OUT);
    assign busy    = (state_q != S_IDLE);
    assign y_data  = y_q;

endmodule

// File: tb/tb_lpc_synth_filter.sv
// Testbench for lpc_synth_filter: behavioural reference model plus directed vectors.
// Latency: n/a (bench).
// Backpressure: drives y_ready low in the handshake test, otherwise high.
module tb_lpc_synth_filter;

    localparam int ORDER = 10;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int CF    = 12;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 coef_wr_en = 1'b0;
    logic [3:0]           coef_wr_addr = '0;
    logic signed [CW-1:0] coef_wr_data = '0;
    logic                 hist_clr = 1'b0;
    logic                 e_valid = 1'b0;
    logic                 e_ready;
    logic signed [DW-1:0] e_data = '0;
    logic                 y_valid;
    logic                 y_ready = 1'b1;
    logic signed [DW-1:0] y_data;
    logic                 busy;

    always #5 clk = ~clk;

    lpc_synth_filter #(
        .ORDER(ORDER), .DATA_W(DW), .COEF_W(CW), .COEF_FRAC(CF), .ACC_W(40)
    ) dut (
        .clk(clk), .reset(reset),
        .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
        .hist_clr(hist_clr),
        .e_valid(e_valid), .e_ready(e_ready), .e_data(e_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
        .busy(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases: 0 idle, 1 computing, 2 presenting output.
    int  m_coef [1:ORDER];
    int  m_hist [1:ORDER];
    int  m_phase = 0;
    int  m_cnt   = 0;
    int  m_y     = 0;
    bit  m_on    = 1'b0;

    function automatic int model_y(input int e);
        longint acc;
        acc = longint'(e) * (longint'(1) <<< CF);
        for (int k = 1; k <= ORDER; k++) begin
            acc = acc - longint'(m_coef[k]) * longint'(m_hist[k]);
        end
        acc = (acc + (longint'(1) <<< (CF - 1))) >>> CF;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_on = 1'b1;
            m_phase = 0;
            m_y = 0;
            for (int k = 1; k <= ORDER; k++) begin
                m_coef[k] = 0;
                m_hist[k] = 0;
            end
        end else if (m_on) begin
            case (m_phase)
                0: begin
                    if (coef_wr_en && coef_wr_addr >= 1 && coef_wr_addr <= ORDER)
                        m_coef[coef_wr_addr] = int'(coef_wr_data);
                    if (hist_clr)
                        for (int k = 1; k <= ORDER; k++) m_hist[k] = 0;
                    if (e_valid) begin
                        m_y = model_y(int'(e_data));
                        for (int k = ORDER; k >= 2; k--) m_hist[k] = m_hist[k-1];
                        m_hist[1] = m_y;
                        m_phase = 1;
                        m_cnt = ORDER + 1;  // cycles without y_valid after acceptance
                    end
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_phase = 2;
                end
                default: begin
                    if (y_ready) m_phase = 0;
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_on) begin
            check("e_ready", e_ready, m_phase == 0);
            check("busy",    busy,    m_phase != 0);
            check("y_valid", y_valid, m_phase == 2);
            if (m_phase == 2) check("y_data", y_data, m_y);
        end
    end

    // Collect completed outputs for the literal checks.
    int got[$];
    always @(negedge clk) begin
        if (m_on && !reset && y_valid === 1'b1 && y_ready) got.push_back(int'(y_data));
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int k, input int v);
        coef_wr_en   = 1'b1;
        coef_wr_addr = 4'(k);
        coef_wr_data = CW'(v);
        tick();
        coef_wr_en = 1'b0;
    endtask

    task automatic send(input int e, input bit clr = 0, input bit we = 0,
                        input int k = 0, input int v = 0);
        bit acc = 1'b0;
        e_valid = 1'b1;
        e_data = DW'(e);
        hist_clr = clr;
        coef_wr_en = we;
        coef_wr_addr = 4'(k);
        coef_wr_data = CW'(v);
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = e_ready;
            tick();
        end
        if (!acc) check("send_timeout", 0, 1);
        e_valid = 1'b0;
        hist_clr = 1'b0;
        coef_wr_en = 1'b0;
    endtask

    task automatic get(output int y);
        for (int i = 0; i < 200 && got.size() == 0; i++) tick();
        if (got.size() == 0) begin
            check("get_timeout", 0, 1);
            y = 0;
        end else begin
            y = got.pop_front();
        end
    endtask

    task automatic run(input int e, output int y);
        send(e);
        get(y);
    endtask

    initial begin
        int y, n, y0;
        int ev [4];

        // Reset state
        reset = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("rst_y_data", y_data, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_e_ready", e_ready, 1);
        check("rst_busy", busy, 0);
        tick();
        reset = 1'b0;

        // Decaying response, a[1] = -0.5
        wr(1, -2048);
        ev = '{4096, 0, 0, 0};
        foreach (ev[i]) begin
            run(ev[i], y);
            check($sformatf("decay%0d", i), y, 4096 >>> i);
        end

        // Saturation, a[1] = -2.0
        wr(1, -8192);
        send(20000, 1); get(y); check("sat_pos0", y, 20000);
        run(0, y);               check("sat_pos1", y, 32767);
        send(-20000, 1); get(y); check("sat_neg0", y, -20000);
        run(0, y);               check("sat_neg1", y, -32768);

        // Rounding half up: 1.5 -> 2, 0.5*2 -> 1, -1.5 -> -1
        wr(1, -2048);
        send(3, 1); get(y); check("rnd0", y, 3);
        run(0, y);          check("rnd1", y, 2);
        run(0, y);          check("rnd2", y, 1);
        send(-3, 1); get(y); check("rnd3", y, -3);
        run(0, y);           check("rnd4", y, -1);

        // Latency and output stall
        y_ready = 1'b0;
        send(1000, 1);
        n = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (y_valid) break;
            n++;
            tick();
        end
        check("latency", n, ORDER + 2);
        y0 = int'(y_data);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("stall_y_data", y_data, y0);
            check("stall_e_ready", e_ready, 0);
        end
        tick();
        y_ready = 1'b1;
        get(y); check("stall_out", y, 1000);

        // Coefficient write while busy is ignored; in idle it is applied
        send(4096, 1);
        wr(1, 4096);
        get(y);    check("busy_wr0", y, 4096);
        run(0, y); check("busy_wr1", y, 2048);
        wr(1, 4096);
        run(0, y); check("idle_wr", y, -2048);

        // Write coincident with acceptance: new a[1]=0 used, hist[1]=-2048 ignored
        send(5, 0, 1, 1, 0); get(y); check("wr_with_e", y, 5);
        // Clear coincident with acceptance: a[1]=-0.5 but history seen as zero
        wr(1, -2048);
        send(7, 1); get(y); check("clr_with_e", y, 7);

        // All coefficients zero, plus out-of-range addresses ignored
        for (int k = 1; k <= ORDER; k++) wr(k, 0);
        wr(0, 1000);
        wr(15, 1000);
        wr(11, 1000);
        for (int i = 0; i < 8; i++) begin
            int e;
            e = int'($signed(16'($urandom_range(0, 65535))));
            send(e, i[0]);
            get(y);
            check("passthru", y, e);
        end

        // Reset in the middle of the MAC sequence
        wr(1, -2048);
        send(100);
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < ORDER + 5; i++) begin
            @(negedge clk);
            check("abort_no_valid", y_valid, 0);
            check("abort_e_ready", e_ready, 1);
            tick();
        end
        check("abort_no_output", got.size(), 0);
        run(123, y); check("after_reset", y, 123);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
